// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared types and constants for the EX-stage ALU controller and its mul/div sequencer.
// The sequencer is only built when RV_MULDIV_EN is defined.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_ADDI = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRA  = 4'b0101,
        OP_SLL  = 4'b0110,
        OP_BEQ  = 4'b0111,
        OP_AND  = 4'b1000,
        OP_SLTI = 4'b1001,
        OP_SLT  = 4'b1010,
        OP_BGE  = 4'b1011,
        OP_SRL  = 4'b1100,
        OP_BLT  = 4'b1101,
        OP_BNE  = 4'b1110,
        OP_JAL  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_JUMP   = 2'b11;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_REM    = 3'b110;

    // Funct3 bit 2 separates the divide family from the multiply family.
    function automatic logic md_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_seq.sv
// Iterative RV32M/RV64M sequencer: one shift-add or restoring-subtract step per cycle,
// operating on operand magnitudes with sign fix-up applied to the final result.
module muldiv_seq
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_ready,
    output logic            o_calc,
    output logic            o_result_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int CNT_W = $clog2(XLEN);

    md_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_f3;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_b;
    logic               r_valid;
    logic [XLEN-1:0]    r_result;

    logic               w_div;
    logic               w_s1;
    logic               w_s2;
    logic               w_neg1;
    logic               w_neg2;
    logic [XLEN-1:0]    w_abs1;
    logic [XLEN-1:0]    w_abs2;
    logic               w_div0;
    logic               w_ovf;
    logic [XLEN-1:0]    w_fast_res;

    assign w_div  = md_is_div(i_funct3);
    assign w_s1   = (i_funct3 == MD_MULH) || (i_funct3 == MD_MULHSU) ||
                    (i_funct3 == MD_DIV)  || (i_funct3 == MD_REM);
    assign w_s2   = (i_funct3 == MD_MULH) || (i_funct3 == MD_DIV) || (i_funct3 == MD_REM);
    assign w_neg1 = w_s1 & i_rs1[XLEN-1];
    assign w_neg2 = w_s2 & i_rs2[XLEN-1];
    assign w_abs1 = w_neg1 ? -i_rs1 : i_rs1;
    assign w_abs2 = w_neg2 ? -i_rs2 : i_rs2;

    assign w_div0 = w_div & (i_rs2 == '0);
    assign w_ovf  = w_div & ~i_funct3[0] & (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (i_rs2 == '1);

    // Funct3 bit 1 selects the remainder flavour within the divide family.
    always_comb begin
        w_fast_res = '0;
        if (i_funct3[1])
            w_fast_res = w_div0 ? i_rs1 : '0;
        else
            w_fast_res = w_div0 ? '1 : i_rs1;
    end

    logic [XLEN:0]      w_mul_sum;
    logic [XLEN:0]      w_rem_sh;
    logic [XLEN:0]      w_diff;
    logic               w_ge;
    logic [XLEN-1:0]    w_nhi;
    logic [XLEN-1:0]    w_nlo;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_quot;
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_final;

    // Multiply keeps {acc, multiplier} in {hi, lo}; divide keeps {remainder, dividend/quotient}.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_rem_sh  = {r_hi, r_lo[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_ge      = ~w_diff[XLEN];

    always_comb begin
        w_nhi = '0;
        w_nlo = '0;
        if (md_is_div(r_f3)) begin
            w_nhi = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
            w_nlo = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_nhi = w_mul_sum[XLEN:1];
            w_nlo = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end
    end

    assign w_prod = r_neg_q ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};
    assign w_quot = r_neg_q ? -w_nlo : w_nlo;
    assign w_rem  = r_neg_r ? -w_nhi : w_nhi;

    always_comb begin
        w_final = '0;
        if (md_is_div(r_f3))
            w_final = r_f3[1] ? w_rem : w_quot;
        else if (r_f3 == MD_MUL)
            w_final = w_prod[XLEN-1:0];
        else
            w_final = w_prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else if (i_flush) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (i_start) begin
                        r_f3    <= i_funct3;
                        r_cnt   <= '0;
                        r_neg_q <= w_neg1 ^ w_neg2;
                        r_neg_r <= w_neg1;
                        r_hi    <= '0;
                        r_lo    <= w_abs1;
                        r_b     <= w_abs2;
                        if (w_div0 || w_ovf) begin
                            r_state  <= DONE;
                            r_valid  <= 1'b1;
                            r_result <= w_fast_res;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_hi  <= w_nhi;
                    r_lo  <= w_nlo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(XLEN-1)) begin
                        r_state  <= DONE;
                        r_valid  <= 1'b1;
                        r_result <= w_final;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready        = (r_state == IDLE);
    assign o_calc         = (r_state == CALC);
    assign o_result_valid = r_valid;
    assign o_result       = r_result;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU controller: combinational ALUOp/Funct3/Funct7 decode plus, when
// RV_MULDIV_EN is defined, the iterative M-extension sequencer and its pipeline stall.
module alu_ctrl_muldiv
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            req_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [3:0]      Operation,
    output logic            is_muldiv,
    output logic            req_ready,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] md_result
);

    logic    w_is_muldiv;
    alu_op_e w_op;

    always_comb begin
        w_op = OP_ADD;
        case (ALUOp)
            ALUOP_BRANCH: begin
                case (Funct3)
                    3'b000:  w_op = OP_BEQ;
                    3'b001:  w_op = OP_BNE;
                    3'b100:  w_op = OP_BLT;
                    3'b101:  w_op = OP_BGE;
                    default: w_op = OP_ADD;
                endcase
            end
            ALUOP_RTYPE: begin
                case (Funct3)
                    3'b000: begin
                        if (Funct7 == F7_BASE)
                            w_op = OP_ADD;
                        else if (Funct7 == F7_ALT)
                            w_op = OP_SUB;
                        else
                            w_op = OP_ADDI;
                    end
                    3'b001:  w_op = OP_SLL;
                    3'b010:  w_op = (Funct7 == F7_BASE) ? OP_SLT : OP_SLTI;
                    3'b100:  w_op = OP_XOR;
                    3'b101:  w_op = (Funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                    3'b110:  w_op = OP_OR;
                    3'b111:  w_op = OP_AND;
                    default: w_op = OP_ADD;
                endcase
            end
            ALUOP_JUMP: w_op = (Funct3 == 3'b000) ? OP_ADD : OP_JAL;
            ALUOP_MEM:  w_op = OP_ADD;
            default:    w_op = OP_ADD;
        endcase
        // EX consumes md_result for M ops, so the ALU is parked on ADD.
        if (w_is_muldiv)
            w_op = OP_ADD;
    end

    assign Operation = w_op;
    assign is_muldiv = w_is_muldiv;

`ifdef RV_MULDIV_EN
    logic            w_accept;
    logic            w_ready;
    logic            w_calc;
    logic            w_valid;
    logic [XLEN-1:0] w_result;

    assign w_is_muldiv = (ALUOp == ALUOP_RTYPE) && (Funct7 == F7_MULDIV);
    assign w_accept    = req_valid & w_is_muldiv & ~flush;

    muldiv_seq #(
        .XLEN(XLEN)
    ) u_seq (
        .i_clk          (clk),
        .i_rst_n        (reset),
        .i_start        (w_accept),
        .i_flush        (flush),
        .i_funct3       (Funct3),
        .i_rs1          (rs1),
        .i_rs2          (rs2),
        .o_ready        (w_ready),
        .o_calc         (w_calc),
        .o_result_valid (w_valid),
        .o_result       (w_result)
    );

    // The result cycle drops stall so the instruction retires together with md_result.
    assign stall        = (req_valid & w_is_muldiv & ~w_valid) | w_calc;
    assign req_ready    = w_ready;
    assign result_valid = w_valid;
    assign md_result    = w_result;
`else
    logic w_unused;

    assign w_is_muldiv  = 1'b0;
    assign stall        = 1'b0;
    assign req_ready    = 1'b1;
    assign result_valid = 1'b0;
    assign md_result    = '0;
    assign w_unused     = ^{clk, reset, req_valid, flush, rs1, rs2};
`endif

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Self-checking bench for alu_ctrl_muldiv; the mul/div section is built only with RV_MULDIV_EN.
module tb_alu_ctrl_muldiv;

    localparam int XLEN = 32;
`ifdef RV_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic            req_valid;
    logic            flush;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [3:0]      Operation;
    logic            is_muldiv;
    logic            req_ready;
    logic            stall;
    logic            result_valid;
    logic [XLEN-1:0] md_result;

    int n_checks = 0;
    int n_fail   = 0;

    alu_ctrl_muldiv #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .ALUOp        (ALUOp),
        .Funct7       (Funct7),
        .Funct3       (Funct3),
        .req_valid    (req_valid),
        .flush        (flush),
        .rs1          (rs1),
        .rs2          (rs2),
        .Operation    (Operation),
        .is_muldiv    (is_muldiv),
        .req_ready    (req_ready),
        .stall        (stall),
        .result_valid (result_valid),
        .md_result    (md_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_dec(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
        if (MD_EN && op == 2'b10 && f7 == 7'h01) return 4'b0000;
        case (op)
            2'b01: case (f3)
                3'd0: return 4'b0111;
                3'd1: return 4'b1110;
                3'd4: return 4'b1101;
                3'd5: return 4'b1011;
                default: return 4'b0000;
            endcase
            2'b10: case (f3)
                3'd0: return (f7 == 7'h00) ? 4'b0000 : (f7 == 7'h20) ? 4'b0001 : 4'b0010;
                3'd1: return 4'b0110;
                3'd2: return (f7 == 7'h00) ? 4'b1010 : 4'b1001;
                3'd4: return 4'b0100;
                3'd5: return (f7 == 7'h20) ? 4'b0101 : 4'b1100;
                3'd6: return 4'b0011;
                3'd7: return 4'b1000;
                default: return 4'b0000;
            endcase
            2'b11: return (f3 == 3'd0) ? 4'b0000 : 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

`ifdef RV_MULDIV_EN
    logic [XLEN-1:0] last_res = '0;

    function automatic logic [31:0] md_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] ua64, ub64, up;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = ua64 * ub64; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        bit          fast;
        int          lat;
        exp  = md_model(f3, a, b);
        fast = f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
        lat  = fast ? 0 : XLEN;
        ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = f3; rs1 = a; rs2 = b; req_valid = 1'b1;
        #1;
        chk({tag, "_accept_stall"}, stall, 1);
        chk({tag, "_accept_ready"}, req_ready, 1);
        chk({tag, "_is_muldiv"}, is_muldiv, 1);
        chk({tag, "_op_zero"}, Operation, 0);
        @(posedge clk); #1;
        for (int k = 0; k <= lat; k++) begin
            chk({tag, "_rv"}, result_valid, (k == lat));
            if (k == lat) begin
                chk({tag, "_result"}, md_result, exp);
                chk({tag, "_done_stall"}, stall, 0);
            end else begin
                chk({tag, "_busy_stall"}, stall, 1);
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, "_rv_drop"}, result_valid, 0);
        chk({tag, "_ready_back"}, req_ready, 1);
        chk({tag, "_held"}, md_result, exp);
        last_res = exp;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask
`endif

    initial begin
        logic [6:0] f7s [4];
        f7s = '{7'h00, 7'h20, 7'h01, 7'h55};
        reset = 1'b0; ALUOp = '0; Funct7 = '0; Funct3 = '0;
        req_valid = 1'b0; flush = 1'b0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rv", result_valid, 0);
        chk("rst_result", md_result, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_stall", stall, 0);
        reset = 1'b1;

        for (int op = 0; op < 4; op++) begin
            for (int f3 = 0; f3 < 8; f3++) begin
                for (int j = 0; j < 4; j++) begin
                    ALUOp = 2'(op); Funct3 = 3'(f3); Funct7 = f7s[j];
                    #1;
                    chk("decode", Operation, exp_dec(ALUOp, Funct3, Funct7));
                    chk("decode_md", is_muldiv, MD_EN && ALUOp == 2'b10 && Funct7 == 7'h01);
                end
            end
        end
        @(posedge clk); #1;

`ifdef RV_MULDIV_EN
        run_md(3'd0, 32'hFFFFFFFD, 32'd7, "mul");
        run_md(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu");
        run_md(3'd4, 32'hFFFFFFF9, 32'd2, "div");
        run_md(3'd6, 32'hFFFFFFF9, 32'd2, "rem");
        run_md(3'd5, 32'd1234, 32'd0, "divu0");
        run_md(3'd4, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_md(3'd6, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
        run_md(3'd1, 32'h80000000, 32'h80000000, "mulh");
        run_md(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  rf3;
            logic [31:0] ra, rb;
            int          sel;
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 0) rb = '0;
            if (sel == 1) begin ra = 32'h80000000; rb = '1; end
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            run_md(rf3, ra, rb, "rand");
        end

        ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        repeat (8) @(posedge clk);
        #1;
        chk("flush_busy", stall, 1);
        flush = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ready", req_ready, 1);
        chk("flush_rv", result_valid, 0);
        chk("flush_stall", stall, 0);
        chk("flush_held", md_result, last_res);
        for (int k = 0; k < XLEN + 4; k++) begin
            @(posedge clk); #1;
            chk("flush_no_rv", result_valid, 0);
        end
        run_md(3'd0, 32'd5, 32'd9, "post_flush");

        ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rv", result_valid, 0);
        chk("midrst_result", md_result, 0);
        chk("midrst_ready", req_ready, 1);
        chk("midrst_stall", stall, 0);
        reset = 1'b1;
        for (int k = 0; k < XLEN + 4; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_rv", result_valid, 0);
        end
        run_md(3'd5, 32'd1000, 32'd7, "post_rst");
`else
        ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd9; req_valid = 1'b1;
        #1;
        chk("nomd_op", Operation, 4'b0010);
        chk("nomd_stall", stall, 0);
        chk("nomd_is_md", is_muldiv, 0);
        chk("nomd_ready", req_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("nomd_rv", result_valid, 0);
            chk("nomd_result", md_result, 0);
        end
        req_valid = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
